// File: rtl/up_down_counter_n_if.sv
// Purpose: control/data bundle for up_down_counter_n.
// Signals:
//   en_b     count enable, active-low (master -> slave)
//   load_b   synchronous parallel load, active-low (master -> slave)
//   up       direction, 1 = up, 0 = down (master -> slave)
//   load_in  parallel load data, N bits (master -> slave)
//   q        registered counter value, N bits (slave -> master)
//   rco_b    ripple carry/borrow out, active-low, combinational (slave -> master)
interface up_down_counter_n_if #(
  parameter int unsigned N = 4
);
  logic         en_b;
  logic         load_b;
  logic         up;
  logic [N-1:0] load_in;
  logic [N-1:0] q;
  logic         rco_b;

  modport master (
    output en_b, load_b, up, load_in,
    input  q, rco_b
  );

  modport slave (
    input  en_b, load_b, up, load_in,
    output q, rco_b
  );
endinterface

// File: rtl/up_down_counter_n.sv
// Purpose: N-bit synchronous up/down counter, 74x191 style, cascadable via
//          rco_b -> en_b of the next stage.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset, clears the count
//   bus   up_down_counter_n_if.slave: en_b, load_b, up, load_in in; q, rco_b out
// Options:
//   UDC_SATURATE_EN  when defined, counting saturates at all-ones / zero
//                    instead of wrapping; load is unaffected.
module up_down_counter_n #(
  parameter int unsigned N = 4
) (
  input  logic               clk,
  input  logic               rst,
  up_down_counter_n_if.slave bus
);

  localparam logic [N-1:0] MAX_VAL = {N{1'b1}};
  localparam logic [N-1:0] MIN_VAL = '0;

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         tc_c;

  // Next-count selection: load beats enable, enable gates direction.
  always_comb begin
    q_d = q_q;
    if (!bus.load_b) begin
      q_d = bus.load_in;
    end else if (!bus.en_b) begin
      if (bus.up) begin
`ifdef UDC_SATURATE_EN
        if (q_q != MAX_VAL) q_d = q_q + N'(1);
`else
        q_d = q_q + N'(1);
`endif
      end else begin
`ifdef UDC_SATURATE_EN
        if (q_q != MIN_VAL) q_d = q_q - N'(1);
`else
        q_d = q_q - N'(1);
`endif
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  // Terminal count follows the current direction, so rco_b reacts to up
  // and en_b within the same cycle without waiting for an edge.
  always_comb begin
    tc_c = bus.up ? (q_q == MAX_VAL) : (q_q == MIN_VAL);
  end

  assign bus.q     = q_q;
  assign bus.rco_b = ~(tc_c & ~bus.en_b);

endmodule

// File: tb/tb_up_down_counter_n.sv
// Purpose: directed self-checking bench for up_down_counter_n, running an
//          N=4 and an N=5 instance side by side. Honors UDC_SATURATE_EN.
module tb_up_down_counter_n;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  up_down_counter_n_if #(.N(4)) if4 ();
  up_down_counter_n_if #(.N(5)) if5 ();

  up_down_counter_n #(.N(4)) u_cnt4 (.clk(clk), .rst(rst), .bus(if4));
  up_down_counter_n #(.N(5)) u_cnt5 (.clk(clk), .rst(rst), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference next value for one enabled count step.
  function automatic int nxt(input int v, input bit u, input int mx);
`ifdef UDC_SATURATE_EN
    if (u) return (v == mx) ? mx : v + 1;
    else   return (v == 0)  ? 0  : v - 1;
`else
    if (u) return (v == mx) ? 0  : v + 1;
    else   return (v == 0)  ? mx : v - 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit lb, input bit e, input bit u, input int l4, input int l5);
    if4.load_b = lb; if4.en_b = e; if4.up = u; if4.load_in = 4'(l4);
    if5.load_b = lb; if5.en_b = e; if5.up = u; if5.load_in = 5'(l5);
  endtask

  task automatic chk_q(input string tag, input int e4, input int e5);
    check({tag, "_q4"}, 32'(if4.q), 32'(e4));
    check({tag, "_q5"}, 32'(if5.q), 32'(e5));
  endtask

  task automatic chk_rco(input string tag, input bit e4, input bit e5);
    check({tag, "_rco4"}, 32'(if4.rco_b), 32'(e4));
    check({tag, "_rco5"}, 32'(if5.rco_b), 32'(e5));
  endtask

  int e4;
  int e5;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    tick();
    tick();
    chk_q("reset", 0, 0);
    chk_rco("reset", 1'b1, 1'b1);

    // Count a little, then reset asynchronously mid-cycle.
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 3, 3);
    tick();
    chk_q("load3", 3, 3);
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    tick();
    tick();
    chk_q("pre_rst", 5, 5);
    #2 rst = 1'b1;
    #1 chk_q("async_rst", 0, 0);
    tick();
    chk_q("rst_held", 0, 0);
    rst = 1'b0;

    // Load zero with enable off, then hold.
    drive(1'b0, 1'b1, 1'b1, 0, 0);
    tick();
    chk_q("load0", 0, 0);
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    tick();
    tick();
    chk_q("hold", 0, 0);
    chk_rco("hold", 1'b1, 1'b1);

    // Up count for 32 edges.
    e4 = 0; e5 = 0;
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      chk_rco("up", e4 != 15, e5 != 31);
      tick();
      e4 = nxt(e4, 1'b1, 15);
      e5 = nxt(e5, 1'b1, 31);
      chk_q("up", e4, e5);
    end

    // Down count for 32 edges from all-ones.
    drive(1'b0, 1'b0, 1'b0, 15, 31);
    tick();
    chk_q("load_max", 15, 31);
    e4 = 15; e5 = 31;
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      chk_rco("down", e4 != 0, e5 != 0);
      tick();
      e4 = nxt(e4, 1'b0, 15);
      e5 = nxt(e5, 1'b0, 31);
      chk_q("down", e4, e5);
    end

    // Load wins over an active enable.
    drive(1'b0, 1'b0, 1'b1, 10, 10);
    tick();
    chk_q("load_prio", 10, 10);
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    tick();
    chk_q("after_load_dn", 9, 9);

    // Mid-stream load then continue up.
    drive(1'b0, 1'b0, 1'b1, 5, 21);
    tick();
    chk_q("mid_load", 5, 21);
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    tick();
    chk_q("mid_up", 6, 22);

    // Enable gating at terminal count.
    drive(1'b0, 1'b1, 1'b1, 15, 31);
    tick();
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    tick();
    chk_q("gate_hold", 15, 31);
    chk_rco("gate_hold", 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    #1 chk_rco("en_fall", 1'b0, 1'b0);
    tick();
    chk_q("top_step", nxt(15, 1'b1, 15), nxt(31, 1'b1, 31));

    // Direction flip at zero changes rco_b without a clock edge.
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    chk_q("zero", 0, 0);
    #1 if4.en_b = 1'b0; if5.en_b = 1'b0;
    #1 chk_rco("zero_up", 1'b1, 1'b1);
    if4.up = 1'b0; if5.up = 1'b0;
    #1 chk_rco("zero_dn", 1'b0, 1'b0);

    // Loading a terminal value with enable on asserts rco_b next cycle.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 15, 31);
    #1 chk_rco("pre_tload", 1'b1, 1'b1);
    tick();
    chk_q("tload", 15, 31);
    chk_rco("tload", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
